// File: rtl/mod10_mon_pkg.sv
// Shared types and helpers for the decade counter monitor.
// Optional build macro consumed by the top: MOD10_MON_STICKY_ERR_EN.
package mod10_mon_pkg;

   localparam int unsigned MOD_DEFAULT = 10;
   localparam int unsigned NM_W        = 16;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      LOCKED = 2'd1,
      FAULT  = 2'd2
   } state_t;

   // Successor of value in a modulo-mod sequence; wraps mod-1 back to zero.
   function automatic logic [NM_W-1:0] next_mod(input logic [NM_W-1:0] value,
                                                input logic [NM_W-1:0] mod);
      logic [NM_W-1:0] res;
      res = value + NM_W'(1);
      if (value == mod - NM_W'(1)) begin
         res = '0;
      end
      return res;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/mod_10_count_monitor.sv
// Receive-side checker for a decade counter bus: lock tracking, error and wrap reporting.
// Build option: define MOD10_MON_STICKY_ERR_EN to make err a level held until reset.
module mod_10_count_monitor
   import mod10_mon_pkg::*;
#(
   parameter int unsigned MOD      = MOD_DEFAULT,
   parameter int unsigned CNT_W    = 4,
   parameter int unsigned LOCK_LEN = 3,
   parameter int unsigned ERR_W    = 8,
   parameter int unsigned DEC_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [CNT_W-1:0] count_in,
   output logic             locked,
   output logic             err,
   output logic [ERR_W-1:0] err_count,
   output logic             wrap,
   output logic [DEC_W-1:0] decade_count
);

   localparam int unsigned MC_W = 4;

   state_t           state;
   state_t           state_nxt;
   logic [MC_W-1:0]  match_cnt;
   logic [MC_W-1:0]  match_cnt_nxt;
   logic [CNT_W-1:0] prev;
   logic             en_d;
   logic [CNT_W-1:0] exp_c;
   logic             legal_c;
   logic             match_c;
   logic             err_c;
   logic             wrap_c;

   // Expected sample models the counter's one-clock update latency.
   always_comb begin
      exp_c = prev;
      if (en_d) begin
         exp_c = CNT_W'(next_mod(NM_W'(prev), NM_W'(MOD)));
      end
   end

   assign legal_c = ({1'b0, count_in} < (CNT_W+1)'(MOD));
   assign match_c = legal_c && (count_in == exp_c);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= HUNT;
         match_cnt <= '0;
      end else begin
         state     <= state_nxt;
         match_cnt <= match_cnt_nxt;
      end
   end

   // Next-state and event decode; a mismatch suppresses any wrap on the same sample.
   always_comb begin
      state_nxt     = state;
      match_cnt_nxt = match_cnt;
      err_c         = 1'b0;
      wrap_c        = 1'b0;
      case (state)
         HUNT: begin
            if (match_c) begin
               if (match_cnt == MC_W'(LOCK_LEN - 1)) begin
                  state_nxt     = LOCKED;
                  match_cnt_nxt = '0;
               end else begin
                  match_cnt_nxt = match_cnt + MC_W'(1);
               end
            end else begin
               match_cnt_nxt = '0;
            end
         end
         LOCKED: begin
            if (!match_c) begin
               state_nxt = FAULT;
               err_c     = 1'b1;
            end else if (en_d && (prev == CNT_W'(MOD - 1)) && (count_in == '0)) begin
               wrap_c = 1'b1;
            end
         end
         FAULT: begin
            state_nxt     = HUNT;
            match_cnt_nxt = '0;
         end
         default: begin
            state_nxt     = HUNT;
            match_cnt_nxt = '0;
         end
      endcase
   end

   // Sample history and registered status outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         prev         <= '0;
         en_d         <= 1'b0;
         locked       <= 1'b0;
         err          <= 1'b0;
         wrap         <= 1'b0;
         decade_count <= '0;
      end else begin
         prev   <= count_in;
         en_d   <= enable;
         locked <= (state_nxt == LOCKED);
         wrap   <= wrap_c;
`ifdef MOD10_MON_STICKY_ERR_EN
         err    <= err | err_c;
`else
         err    <= err_c;
`endif
         if (wrap_c) begin
            decade_count <= decade_count + DEC_W'(1);
         end
      end
   end

   sat_counter #(
      .W (ERR_W)
   ) u_err_cnt (
      .clk   (clk),
      .clr_n (rst),
      .inc   (err_c),
      .count (err_count)
   );

endmodule

// File: tb/tb_mod_10_count_monitor.sv
// Scoreboard bench for mod_10_count_monitor: directed vectors, queued expectations, decoupled monitor.
module tb_mod_10_count_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [3:0] count_in;
   logic       locked;
   logic       err;
   logic [7:0] err_count;
   logic       wrap;
   logic [7:0] decade_count;

   always #5 clk = ~clk;

   mod_10_count_monitor dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .count_in     (count_in),
      .locked       (locked),
      .err          (err),
      .err_count    (err_count),
      .wrap         (wrap),
      .decade_count (decade_count)
   );

   typedef struct {
      int unsigned due;
      logic        l;
      logic        e;
      logic        w;
      logic [7:0]  ec;
      logic [7:0]  dc;
      string       name;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   bit          sticky_seen = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input string f, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s actual=%0d required=%0d (cycle %0d)", nm, f, act, req, cyc);
      end
   endtask

   // Apply one vector and queue the outputs expected after the next rising edge.
   task automatic drive(input logic r, input logic en, input logic [3:0] c,
                        input logic l, input logic e, input logic w,
                        input logic [7:0] ec, input logic [7:0] dc, input string nm);
      exp_t x;
      @(posedge clk);
      #1;
      rst      = r;
      enable   = en;
      count_in = c;
      x.due  = cyc + 1;
      x.l    = l;
      x.w    = w;
      x.ec   = ec;
      x.dc   = dc;
      x.name = nm;
`ifdef MOD10_MON_STICKY_ERR_EN
      x.e         = r ? (e | sticky_seen) : 1'b0;
      sticky_seen = r ? (sticky_seen | e) : 1'b0;
`else
      x.e = e;
`endif
      q.push_back(x);
   endtask

   // Monitor: compares DUT outputs against due expectations on the falling edge.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].due <= cyc) begin
            x = q.pop_front();
            if (x.due < cyc) begin
               checks++;
               errors++;
               $display("FAIL %s stale expectation due=%0d now=%0d", x.name, x.due, cyc);
            end else begin
               chk(x.name, "locked", 8'(locked), 8'(x.l));
               chk(x.name, "err", 8'(err), 8'(x.e));
               chk(x.name, "wrap", 8'(wrap), 8'(x.w));
               chk(x.name, "err_count", err_count, x.ec);
               chk(x.name, "decade_count", decade_count, x.dc);
            end
         end
      end
   end

   initial begin
      logic [3:0] a;
      logic [3:0] b;
      int         ecnt;
      int         spin;

      rst      = 1'b0;
      enable   = 1'b0;
      count_in = 4'd0;

      drive(0, 0, 4'd0, 0, 0, 0, 8'd0, 8'd0, "reset0");
      drive(0, 0, 4'd0, 0, 0, 0, 8'd0, 8'd0, "reset1");

      // Counting run: lock after third match, wrap pulse on every 9->0 while locked.
      for (int k = 0; k <= 1004; k++) begin
         drive(1, 1, 4'(k % 10), (k >= 2), 0, (k >= 10 && (k % 10) == 0),
               8'd0, 8'(k / 10), "count_run");
      end

      // Disable while locked; counter settles at 5, then an illegal jump to 7.
      drive(1, 0, 4'd5, 1, 0, 0, 8'd0, 8'd100, "settle5");
      drive(1, 0, 4'd7, 0, 1, 0, 8'd1, 8'd100, "hold_jump7");
      drive(1, 0, 4'd7, 0, 0, 0, 8'd1, 8'd100, "fault7");
      drive(1, 0, 4'd7, 0, 0, 0, 8'd1, 8'd100, "relock7_a");
      drive(1, 0, 4'd7, 0, 0, 0, 8'd1, 8'd100, "relock7_b");
      drive(1, 0, 4'd7, 1, 0, 0, 8'd1, 8'd100, "relock7_c");

      // Out-of-range value while locked, then never accepted during hunt.
      drive(1, 0, 4'd12, 0, 1, 0, 8'd2, 8'd100, "illegal12");
      drive(1, 0, 4'd12, 0, 0, 0, 8'd2, 8'd100, "fault12");
      for (int k = 0; k < 5; k++) begin
         drive(1, 0, 4'd12, 0, 0, 0, 8'd2, 8'd100, "hunt12");
      end
      drive(1, 0, 4'd3, 0, 0, 0, 8'd2, 8'd100, "recover3_a");
      drive(1, 0, 4'd3, 0, 0, 0, 8'd2, 8'd100, "recover3_b");
      drive(1, 0, 4'd3, 0, 0, 0, 8'd2, 8'd100, "recover3_c");
      drive(1, 0, 4'd3, 1, 0, 0, 8'd2, 8'd100, "recover3_d");

      // 300 errors: err_count saturates at 255 while err keeps pulsing.
      a    = 4'd3;
      ecnt = 2;
      for (int i = 0; i < 300; i++) begin
         b    = (a == 4'd3) ? 4'd4 : 4'd3;
         ecnt = (ecnt < 255) ? ecnt + 1 : 255;
         drive(1, 0, b, 0, 1, 0, 8'(ecnt), 8'd100, "burst_err");
         drive(1, 0, b, 0, 0, 0, 8'(ecnt), 8'd100, "burst_fault");
         drive(1, 0, b, 0, 0, 0, 8'(ecnt), 8'd100, "burst_hunt1");
         drive(1, 0, b, 0, 0, 0, 8'(ecnt), 8'd100, "burst_hunt2");
         drive(1, 0, b, 1, 0, 0, 8'(ecnt), 8'd100, "burst_lock");
         a = b;
      end

      // Count up to 6 while locked, then a one-edge reset.
      drive(1, 1, 4'd3, 1, 0, 0, 8'd255, 8'd100, "run3");
      drive(1, 1, 4'd4, 1, 0, 0, 8'd255, 8'd100, "run4");
      drive(1, 1, 4'd5, 1, 0, 0, 8'd255, 8'd100, "run5");
      drive(1, 1, 4'd6, 1, 0, 0, 8'd255, 8'd100, "run6");
      drive(0, 1, 4'd7, 0, 0, 0, 8'd0, 8'd0, "mid_reset");

      // After reset exp is 0, so 8 mismatches silently; 9->0 in hunt is not a wrap.
      drive(1, 1, 4'd8, 0, 0, 0, 8'd0, 8'd0, "post_rst8");
      drive(1, 1, 4'd9, 0, 0, 0, 8'd0, 8'd0, "post_rst9");
      drive(1, 1, 4'd0, 0, 0, 0, 8'd0, 8'd0, "hunt_wrap0");
      drive(1, 1, 4'd1, 1, 0, 0, 8'd0, 8'd0, "relock1");
      drive(1, 1, 4'd2, 1, 0, 0, 8'd0, 8'd0, "locked2");

      spin = 0;
      while (q.size() > 0 && spin < 10) begin
         @(posedge clk);
         spin++;
      end
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mod_10_count_monitor.md
Name: mod_10_count_monitor

Overview:
- Receive-side checker for the decade counter output bus (`counter_output`, `enable`).
- Samples the 4-bit count every clock and verifies it follows the legal sequence 0..9 with wrap.
- Enforces hold-when-disabled and one-step-when-enabled behaviour.
- Reports lock status, error pulses, a saturating error tally and a decade (wrap) count for status registers and the board display path.

Parameters:
- MOD, 10: counter modulus; legal values 0..MOD-1.
- CNT_W, 4: width of the monitored count bus.
- LOCK_LEN, 3: consecutive correct samples required to declare lock (1..15).
- ERR_W, 8: width of the saturating error counter.
- DEC_W, 8: width of the wrapping decade counter.

Ports:
- clk, input, 1: rising-edge clock; the single clock of the block.
- rst, input, 1: synchronous, active-low reset; sampled on rising `clk`.
- enable, input, 1: same enable driven to the counter under monitor.
- count_in, input, CNT_W: monitored counter output.
- locked, output, 1: high while the state is LOCKED.
- err, output, 1: one-cycle pulse per detected sequence error.
- err_count, output, ERR_W: saturating number of errors since reset.
- wrap, output, 1: one-cycle pulse when a legal (MOD-1) -> 0 step is seen while LOCKED.
- decade_count, output, DEC_W: number of wraps seen while LOCKED; wraps modulo 2^DEC_W.

Behaviour:
- Reset (rst==0 at a clock edge): state=HUNT, locked=0, err=0, wrap=0, err_count=0, decade_count=0, internal prev=0, en_d=0, match_cnt=0.
- Registers every cycle: prev<=count_in, en_d<=enable.
- Expected value: exp = en_d ? ((prev==MOD-1) ? 0 : prev+1) : prev.
  - This models the counter's one-clock update latency.
  - Arithmetic uses CNT_W bits; no overflow past MOD-1.
- Illegal: count_in >= MOD (10..15). Always treated as a mismatch.
- State machine (3 states):
  - HUNT (entry / after reset):
    - count_in==exp and legal: match_cnt++.
    - Otherwise: match_cnt<=0.
    - When match_cnt reaches LOCK_LEN-1 with a further match: go to LOCKED, match_cnt<=0.
    - err is never raised in HUNT.
  - LOCKED:
    - Match: stay.
    - Mismatch or illegal: go to FAULT, err=1 for that cycle, err_count+1 saturating at 2^ERR_W-1.
  - FAULT: unconditionally go to HUNT next cycle, match_cnt<=0. The current sample becomes prev, because prev always updates.
- locked is a registered function of state; it goes high on the cycle after the final matching sample.
- err and wrap are registered; each asserts the cycle after the offending or wrapping sample.
- wrap: LOCKED, en_d==1, prev==MOD-1, count_in==0 (a legal match). decade_count+1 on the same edge.
- Simultaneous events: mismatch wins. No wrap is counted on a sample that also raises err.
- Disabled hold: with enable low, any change of count_in while LOCKED is an error.
- Mid-operation reset: all outputs return to reset values on that edge, regardless of state. In-flight err/wrap pulses are dropped.
- Saturation: err_count holds at max; err still pulses.

Optional Feature:
- MOD10_MON_STICKY_ERR_EN
  - Defined: err becomes a sticky level. Set on the first error and cleared only by reset. The FSM still re-hunts and err_count still increments.
  - Undefined: err is the one-cycle pulse described above.

Decomposition:
- Package mod10_mon_pkg:
  - state enum (HUNT, LOCKED, FAULT);
  - MOD_DEFAULT=10;
  - the next_mod(value, mod) function used for exp.
- One sub-module: sat_counter (width param, inc, synchronous active-low clear, saturating output), used for err_count.

Test Plan:
- Reset, then enable=1 with count_in 0,1,2,3… driven one cycle behind enable -> locked=1 one cycle after the 3rd matching sample; err=0 throughout.
- While locked, run 8,9,0 -> one wrap pulse, decade_count 0→1. Run 100 decades -> decade_count=100.
- While locked, enable=0 and count_in jumps 5→7 -> err pulse, err_count=1, locked drops. Relock after 3 held samples of 7.
- Inject count_in=12 while locked -> err, err_count increments, FAULT→HUNT. 12 is never accepted into a lock.
- Force 300 errors (ERR_W=8) -> err_count saturates at 255; err still pulses each time.
- rst=0 for one edge mid-LOCKED at count 6 -> all outputs zero next cycle. With MOD10_MON_STICKY_ERR_EN defined, err stays high after an error until this reset.
